dual_port_memory: RTL and testbench
===================================

Name: dual_port_memory

Overview:
Parametrised successor to the single-port unified memory. One byte-addressable, little-endian RAM is shared by two ports. The instruction port is an asynchronous read-only word fetch. The data port is a request/ready port with configurable wait states, RISC-V funct3 width and sign handling, misalignment/range error reporting, and a hardware clear sequence after reset. It sits between the core's fetch/LSU and the RAM array.

Parameters:
WORD_SIZE, 32, data/address width in bits.
RAM_SIZE, 4096, RAM size in bytes; a power of two and a multiple of 4.
WAIT_STATES, 1, extra cycles inserted before a data access completes (0..15).
CLEAR_ON_RESET, 1, 1 = zero the entire RAM after reset; 0 = skip the clear and go straight to IDLE.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
i_addr  input  WORD_SIZE  instruction fetch byte address.
i_data  output  WORD_SIZE  instruction word, combinational.
d_req  input  1  data request; must be held high until d_ready.
d_we  input  1  1 = store, 0 = load.
d_addr  input  WORD_SIZE  data byte address.
d_wdata  input  WORD_SIZE  store data, taken from the low bytes.
d_funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
d_rdata  output  WORD_SIZE  load result, extended per funct3.
d_ready  output  1  one-cycle completion pulse.
d_err  output  1  valid with d_ready; 1 = access rejected.
busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset: one clock, synchronous, active-high; port names are clk and rst.
- Output values under rst: d_ready=0, d_err=0, d_rdata=0, busy=CLEAR_ON_RESET.
- Reset mid-transaction aborts it: no write occurs and no d_ready is issued. RAM contents are undefined until the clear completes.
- FSM states: CLEAR, IDLE, WAIT, RESP. rst goes to CLEAR if CLEAR_ON_RESET, else to IDLE.
- CLEAR: writes zero to one word per cycle from word 0 upward. After RAM_SIZE/4 cycles it goes to IDLE and busy falls. d_req is ignored during CLEAR. i_data reads the partially cleared array.
- IDLE: on d_req=1, latch d_we, d_addr, d_wdata and d_funct3.
  - Error check: funct3 is 011, 110 or 111; funct3 is 100/101 with d_we=1; H with addr[0]=1; W with addr[1:0]≠0; or d_addr ≥ RAM_SIZE. On error go to RESP with err=1, with no RAM or d_rdata change.
  - Otherwise load the counter with WAIT_STATES and go to WAIT, or to RESP directly if WAIT_STATES=0.
- WAIT: the counter decrements each cycle. At 1 the access executes on the next edge and the FSM enters RESP.
- Access execution:
  - Store writes 1/2/4 byte lanes from d_wdata[7:0] upward.
  - Load assembles bytes little-endian. B/H are sign-extended, BU/HU zero-extended, W is unchanged. The result is registered into d_rdata.
- RESP: d_ready=1 for exactly one cycle, d_err as decided, then return to IDLE. d_req is ignored in RESP.
- Latency and throughput: request seen in IDLE at cycle 0 → d_ready at cycle WAIT_STATES+1. A still-high d_req in the cycle after RESP is a new request. Maximum throughput is one access per WAIT_STATES+2 cycles.
- d_rdata holds its value until the next successful load; stores and errors do not change it.
- Instruction port: i_data = {RAM[a+3],RAM[a+2],RAM[a+1],RAM[a]}, where a = i_addr with bits [1:0] forced to 0, modulo RAM_SIZE. Upper address bits alias; there is no error.
- Write/fetch collision on the same word: i_data shows old data until the write edge and new data afterwards.

Test Plan:
- Reset with CLEAR_ON_RESET=1, RAM_SIZE=64 → busy high for exactly 16 cycles; afterwards i_data=0 for all i_addr 0..60.
- SW 0xDEADBEEF to 0x10, WAIT_STATES=1 → d_ready 2 cycles after acceptance, d_err=0; i_data at i_addr=0x10 reads 0xDEADBEEF.
- Using that word, loads from 0x10: LB → 0xFFFFFFEF; LBU → 0x000000EF; LH at 0x12 → 0xFFFFDEAD; LHU at 0x12 → 0x0000DEAD.
- SB 0x55 to 0x11 → word reads 0xDEAD55EF; only one lane changes.
- Error cases: LW at 0x13, LH at 0x11, SB with funct3=100, and an address equal to RAM_SIZE → each gives d_ready and d_err=1 after WAIT_STATES+1 cycles, with memory and d_rdata unchanged.
- Assert rst during WAIT of SW 0x12345678 to 0x20 with CLEAR_ON_RESET=0 → no d_ready and the word at 0x20 is unchanged. With WAIT_STATES=0 and d_req held high, d_ready pulses every 2 cycles.

Source files
------------

// File: rtl/dual_port_memory.sv
// Byte-addressable RAM shared by an async instruction fetch port and a request/ready data port.
// Data access completes WAIT_STATES+1 cycles after acceptance; d_req must be held until the d_ready pulse.
module dual_port_memory #(
    parameter int WORD_SIZE      = 32,
    parameter int RAM_SIZE       = 4096,
    parameter int WAIT_STATES    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_data,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    input  logic [2:0]           d_funct3,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 d_err,
    output logic                 busy
);
    localparam int AW = $clog2(RAM_SIZE);
    localparam int CW = AW - 2;
    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [3:0] WS        = 4'(WAIT_STATES);
    localparam logic [CW-1:0] CLR_LAST = CW'(RAM_SIZE / 4 - 1);
    localparam logic [WORD_SIZE-1:0] RAM_LIMIT = WORD_SIZE'(RAM_SIZE);

    logic [7:0]           mem [RAM_SIZE];
    logic [1:0]           state;
    logic [3:0]           cnt;
    logic [CW-1:0]        clr_idx;
    logic                 we_q, err_q;
    logic [AW-1:0]        addr_q;
    logic [WORD_SIZE-1:0] wdata_q, rdata_q;
    logic [2:0]           f3_q;

    logic                 direct, err_now, do_access;
    logic                 acc_we;
    logic [AW-1:0]        acc_addr;
    logic [WORD_SIZE-1:0] acc_wdata, ld_val;
    logic [2:0]           acc_f3;
    logic [7:0]           b0, b1, b2, b3;
    logic [AW-1:0]        ia;
    logic                 unused_addr_bits;

    // With zero wait states the access completes straight from IDLE on the live inputs.
    assign direct    = (state == S_IDLE);
    assign acc_we    = direct ? d_we : we_q;
    assign acc_addr  = direct ? d_addr[AW-1:0] : addr_q;
    assign acc_wdata = direct ? d_wdata : wdata_q;
    assign acc_f3    = direct ? d_funct3 : f3_q;

    always_comb begin
        err_now = 1'b0;
        case (d_funct3)
            3'b000:  err_now = 1'b0;
            3'b001:  err_now = d_addr[0];
            3'b010:  err_now = |d_addr[1:0];
            3'b100:  err_now = d_we;
            3'b101:  err_now = d_we | d_addr[0];
            default: err_now = 1'b1;
        endcase
        if (d_addr >= RAM_LIMIT) err_now = 1'b1;
    end

    assign do_access = ~rst & ((direct & d_req & (WS == 4'd0) & ~err_now) |
                               ((state == S_WAIT) & (cnt == 4'd1) & ~err_q));

    assign b0 = mem[acc_addr];
    assign b1 = mem[acc_addr + AW'(1)];
    assign b2 = mem[acc_addr + AW'(2)];
    assign b3 = mem[acc_addr + AW'(3)];

    always_comb begin
        ld_val = '0;
        case (acc_f3[1:0])
            2'b00:   ld_val = {{(WORD_SIZE-8){b0[7] & ~acc_f3[2]}}, b0};
            2'b01:   ld_val = {{(WORD_SIZE-16){b1[7] & ~acc_f3[2]}}, b1, b0};
            default: ld_val = WORD_SIZE'({b3, b2, b1, b0});
        endcase
    end

    assign ia     = {i_addr[AW-1:2], 2'b00};
    assign i_data = WORD_SIZE'({mem[ia + AW'(3)], mem[ia + AW'(2)], mem[ia + AW'(1)], mem[ia]});
    assign unused_addr_bits = ^{i_addr[WORD_SIZE-1:AW], i_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst && state == S_CLEAR) begin
            for (int k = 0; k < 4; k++) mem[{clr_idx, 2'(k)}] <= 8'h00;
        end
        if (do_access && acc_we) begin
            mem[acc_addr] <= acc_wdata[7:0];
            if (acc_f3[1:0] != 2'b00) mem[acc_addr + AW'(1)] <= acc_wdata[15:8];
            if (acc_f3[1:0] == 2'b10) begin
                mem[acc_addr + AW'(2)] <= acc_wdata[23:16];
                mem[acc_addr + AW'(3)] <= acc_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            cnt     <= '0;
            clr_idx <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_idx <= clr_idx + CW'(1);
                    if (clr_idx == CLR_LAST) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (d_req) begin
                        we_q    <= d_we;
                        addr_q  <= d_addr[AW-1:0];
                        wdata_q <= d_wdata;
                        f3_q    <= d_funct3;
                        err_q   <= err_now;
                        if (WS == 4'd0) begin
                            state <= S_RESP;
                            if (!err_now && !d_we) rdata_q <= ld_val;
                        end else begin
                            cnt   <= WS;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Rejected accesses still wait so every response has the same latency.
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                        if (!err_q && !we_q) rdata_q <= ld_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign d_ready = ~rst & (state == S_RESP);
    assign d_err   = d_ready & err_q;
    assign d_rdata = rst ? '0 : rdata_q;
    assign busy    = rst ? (CLEAR_ON_RESET != 0) : (state == S_CLEAR);

endmodule

// File: tb/tb_dual_port_memory.sv
// Bench for dual_port_memory: scoreboarded data port on a cleared 64-byte RAM,
// plus reset-abort (no clear, 2 wait states) and back-to-back (0 wait states) instances.
module tb_dual_port_memory;
    localparam int RS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, d_req, d_we, d_ready, d_err, busy;
    logic [31:0] i_addr, i_data, d_addr, d_wdata, d_rdata;
    logic [2:0]  d_funct3;
    logic        rst_b, d_req_b, d_we_b, d_ready_b, d_err_b, busy_b;
    logic [31:0] i_addr_b, i_data_b, d_addr_b, d_wdata_b, d_rdata_b;
    logic [2:0]  d_funct3_b;
    logic        rst_z, d_req_z, d_we_z, d_ready_z, d_err_z, busy_z;
    logic [31:0] i_addr_z, i_data_z, d_addr_z, d_wdata_z, d_rdata_z;
    logic [2:0]  d_funct3_z;

    dual_port_memory #(.WORD_SIZE(32), .RAM_SIZE(RS), .WAIT_STATES(1), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_data(i_data), .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3), .d_rdata(d_rdata),
        .d_ready(d_ready), .d_err(d_err), .busy(busy));
    dual_port_memory #(.WORD_SIZE(32), .RAM_SIZE(RS), .WAIT_STATES(2), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .rst(rst_b), .i_addr(i_addr_b), .i_data(i_data_b), .d_req(d_req_b), .d_we(d_we_b),
        .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_funct3(d_funct3_b), .d_rdata(d_rdata_b),
        .d_ready(d_ready_b), .d_err(d_err_b), .busy(busy_b));
    dual_port_memory #(.WORD_SIZE(32), .RAM_SIZE(RS), .WAIT_STATES(0), .CLEAR_ON_RESET(0)) dut_z (
        .clk(clk), .rst(rst_z), .i_addr(i_addr_z), .i_data(i_data_z), .d_req(d_req_z), .d_we(d_we_z),
        .d_addr(d_addr_z), .d_wdata(d_wdata_z), .d_funct3(d_funct3_z), .d_rdata(d_rdata_z),
        .d_ready(d_ready_z), .d_err(d_err_z), .busy(busy_z));

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          start;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every d_ready pulse of the main instance is matched against the scoreboard.
    always @(negedge clk) begin
        if (d_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready: got d_ready=1 at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("d_err", {31'b0, d_err}, {31'b0, mon_e.err});
                chk("d_rdata", d_rdata, mon_e.rd);
                chk("latency", cyc - mon_e.start, 32'd2);
            end
        end
    end

    task automatic acc(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ee, input logic [31:0] er);
        exp_t e;
        int n;
        @(negedge clk);
        d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        e.err = ee; e.rd = er; e.start = cyc;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (d_ready !== 1'b1 && n < 20);
        if (d_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got no d_ready in %0d cycles, expected a pulse", n);
        end
        d_req = 1'b0;
    endtask

    task automatic ifetch(input logic [31:0] addr, input logic [31:0] exp);
        i_addr = addr;
        #1;
        chk("i_data", i_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [9:0] rdy_pat, err_pat;
        rst = 1; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0; i_addr = 0;
        rst_b = 1; d_req_b = 0; d_we_b = 0; d_addr_b = 0; d_wdata_b = 0; d_funct3_b = 0; i_addr_b = 0;
        rst_z = 1; d_req_z = 0; d_we_z = 0; d_addr_z = 0; d_wdata_z = 0; d_funct3_z = 0; i_addr_z = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_ready", {31'b0, d_ready}, 32'd0);
        chk("rst_err", {31'b0, d_err}, 32'd0);
        chk("rst_rdata", d_rdata, 32'd0);
        chk("rst_busy_noclear", {31'b0, busy_b}, 32'd0);

        rst = 0;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("clear_cycles", n, 32'd16);
        for (int a = 0; a <= 60; a += 4) ifetch(a, 32'h0);

        acc(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        ifetch(32'h10, 32'hDEADBEEF);
        ifetch(32'h13, 32'hDEADBEEF);
        ifetch(32'h50, 32'hDEADBEEF);
        acc(0, 3'b000, 32'h10, 32'h0, 0, 32'hFFFFFFEF);
        acc(0, 3'b100, 32'h10, 32'h0, 0, 32'h000000EF);
        acc(0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFFDEAD);
        acc(0, 3'b101, 32'h12, 32'h0, 0, 32'h0000DEAD);
        acc(0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF);
        acc(1, 3'b000, 32'h11, 32'hAAAAAA55, 0, 32'hDEADBEEF);
        ifetch(32'h10, 32'hDEAD55EF);
        ifetch(32'h14, 32'h0);
        acc(1, 3'b001, 32'h16, 32'h1234CAFE, 0, 32'hDEADBEEF);
        ifetch(32'h14, 32'hCAFE0000);
        acc(0, 3'b001, 32'h16, 32'h0, 0, 32'hFFFFCAFE);
        acc(0, 3'b000, 32'h17, 32'h0, 0, 32'hFFFFFFCA);
        acc(0, 3'b010, 32'h13, 32'h0, 1, 32'hFFFFFFCA);
        acc(0, 3'b001, 32'h11, 32'h0, 1, 32'hFFFFFFCA);
        acc(1, 3'b100, 32'h10, 32'h77, 1, 32'hFFFFFFCA);
        acc(0, 3'b010, RS, 32'h0, 1, 32'hFFFFFFCA);
        acc(1, 3'b010, RS, 32'h11223344, 1, 32'hFFFFFFCA);
        acc(0, 3'b011, 32'h10, 32'h0, 1, 32'hFFFFFFCA);
        ifetch(32'h10, 32'hDEAD55EF);
        ifetch(32'h0, 32'h0);
        acc(0, 3'b010, 32'h10, 32'h0, 0, 32'hDEAD55EF);
        acc(0, 3'b100, 32'h13, 32'h0, 0, 32'h000000DE);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        // Reset during WAIT must abort the store.
        @(negedge clk);
        rst_b = 0;
        @(negedge clk);
        d_we_b = 1; d_funct3_b = 3'b010; d_addr_b = 32'h20; d_wdata_b = 32'hA5A5A5A5; d_req_b = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (d_ready_b !== 1'b1 && n < 20);
        chk("b_latency", n, 32'd3);
        chk("b_err", {31'b0, d_err_b}, 32'd0);
        d_req_b = 0;
        @(negedge clk);
        d_wdata_b = 32'h12345678; d_req_b = 1;
        @(negedge clk);
        rst_b = 1; d_req_b = 0;
        #1;
        chk("b_rst_ready", {31'b0, d_ready_b}, 32'd0);
        chk("b_rst_rdata", d_rdata_b, 32'd0);
        @(negedge clk);
        rst_b = 0;
        n = 0;
        repeat (6) begin
            if (d_ready_b === 1'b1) n++;
            @(negedge clk);
        end
        chk("b_abort_ready_count", n, 32'd0);
        i_addr_b = 32'h20;
        #1;
        chk("b_abort_word", i_data_b, 32'hA5A5A5A5);

        // Zero wait states with d_req held high: one response every 2 cycles.
        @(negedge clk);
        rst_z = 0;
        @(negedge clk);
        d_we_z = 1; d_funct3_z = 3'b010; d_addr_z = 32'h08; d_wdata_z = 32'hCAFEF00D; d_req_z = 1;
        rdy_pat = '0; err_pat = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rdy_pat[k] = d_ready_z;
            err_pat[k] = d_err_z;
        end
        d_req_z = 0;
        chk("z_ready_pattern", {22'b0, rdy_pat}, 32'h155);
        chk("z_err_pattern", {22'b0, err_pat}, 32'h0);
        @(negedge clk);
        i_addr_z = 32'h08;
        #1;
        chk("z_word", i_data_z, 32'hCAFEF00D);
        @(negedge clk);
        d_we_z = 0; d_funct3_z = 3'b000; d_addr_z = 32'h0B; d_req_z = 1;
        @(negedge clk);
        d_req_z = 0;
        chk("z_lb_ready", {31'b0, d_ready_z}, 32'd1);
        chk("z_lb_rdata", d_rdata_z, 32'hFFFFFFCA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
